// File: rtl/spi_helpers_minion_shift.sv
`default_nettype none
// ============================================================================
// Module      : spi_helpers_minion_shift
// Description : SPI mode-0 minion front end. Oversamples cs_n/sclk/mosi and
//               turns each chip-select frame into pull/push adapter strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_helpers_minion_shift #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs_n,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             pull_en,
    input  logic             pull_msg_val,
    input  logic             pull_msg_spc,
    input  logic [NBITS-3:0] pull_msg_data,
    output logic             push_en,
    output logic             push_msg_val_wrt,
    output logic             push_msg_val_rd,
    output logic [NBITS-3:0] push_msg_data,
    output logic             frame_err
);

    localparam int                 c_CNT_W    = $clog2(NBITS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(NBITS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(NBITS + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    logic [NBITS-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_pull_en;
    logic               r_push_en;
    logic               r_frame_err;

    logic r_cs_s1, r_cs_s2, r_cs_h;
    logic r_sclk_s1, r_sclk_s2, r_sclk_h;
    logic r_mosi_s1, r_mosi_s2;
    logic [1:0] r_warm;
    logic r_cs_armed;

    // A frame may only start after cs_n has genuinely been observed high,
    // so a chip select held low across reset release is not mistaken for a fall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_cs_h     <= 1'b1;
            r_sclk_s1  <= 1'b0;
            r_sclk_s2  <= 1'b0;
            r_sclk_h   <= 1'b0;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
            r_warm     <= 2'b00;
            r_cs_armed <= 1'b0;
        end else begin
            r_cs_s1    <= cs_n;
            r_cs_s2    <= r_cs_s1;
            r_cs_h     <= r_cs_s2;
            r_sclk_s1  <= sclk;
            r_sclk_s2  <= r_sclk_s1;
            r_sclk_h   <= r_sclk_s2;
            r_mosi_s1  <= mosi;
            r_mosi_s2  <= r_mosi_s1;
            r_warm     <= {r_warm[0], 1'b1};
            r_cs_armed <= r_cs_armed | (r_warm[1] & r_cs_s2);
        end
    end

    logic               w_cs_fall;
    logic               w_cs_rise;
    logic               w_sclk_rise;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_CNT_W-1:0] w_cnt_final;

    assign w_cs_fall   = r_cs_armed & r_cs_h & ~r_cs_s2;
    assign w_cs_rise   = ~r_cs_h & r_cs_s2;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h;
    assign w_cnt_inc   = (r_bit_cnt == c_CNT_SAT) ? r_bit_cnt : r_bit_cnt + 1'b1;
    // Count as it will stand once a coincident sclk rise has been shifted in.
    assign w_cnt_final = r_pull_en   ? '0 :
                         w_sclk_rise ? w_cnt_inc : r_bit_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_pull_en   <= 1'b0;
            r_push_en   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_pull_en   <= 1'b0;
            r_push_en   <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_pull_en) begin
                r_shift   <= {pull_msg_val, pull_msg_spc, pull_msg_data};
                r_bit_cnt <= '0;
            end else if (r_state == ST_ACTIVE && w_sclk_rise) begin
                r_shift   <= {r_shift[NBITS-2:0], r_mosi_s2};
                r_bit_cnt <= w_cnt_inc;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= ST_ACTIVE;
                        r_pull_en <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        if (w_cnt_final == c_CNT_FULL) begin
                            r_push_en <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign miso             = r_shift[NBITS-1];
    assign pull_en          = r_pull_en;
    assign push_en          = r_push_en;
    assign frame_err        = r_frame_err;
    assign push_msg_val_wrt = r_shift[NBITS-1];
    assign push_msg_val_rd  = r_shift[NBITS-2];
    assign push_msg_data    = r_shift[NBITS-3:0];

endmodule
`default_nettype wire

// File: tb/tb_spi_helpers_minion_shift.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_helpers_minion_shift
// Description : Self-checking bench for the SPI minion shift front end.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_helpers_minion_shift;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       pull_en;
    logic       pull_msg_val;
    logic       pull_msg_spc;
    logic [5:0] pull_msg_data;
    logic       push_en;
    logic       push_msg_val_wrt;
    logic       push_msg_val_rd;
    logic [5:0] push_msg_data;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_helpers_minion_shift #(.NBITS(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cs_n             (cs_n),
        .sclk             (sclk),
        .mosi             (mosi),
        .miso             (miso),
        .pull_en          (pull_en),
        .pull_msg_val     (pull_msg_val),
        .pull_msg_spc     (pull_msg_spc),
        .pull_msg_data    (pull_msg_data),
        .push_en          (push_en),
        .push_msg_val_wrt (push_msg_val_wrt),
        .push_msg_val_rd  (push_msg_val_rd),
        .push_msg_data    (push_msg_data),
        .frame_err        (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_pull = 0;
    int n_push = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // Pulse counters and observed-push capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (pull_en) n_pull++;
        if (frame_err) n_err++;
        if (push_en) begin
            n_push++;
            obs_q.push_back({push_msg_val_wrt, push_msg_val_rd, push_msg_data});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drives one frame of nbit sclk cycles; abort_at >= 0 pulls reset low
    // before that bit and returns with cs_n still low.
    task automatic do_frame(input int nbit, input logic [7:0] mosi_b,
                            input logic [7:0] pull_b, input int abort_at,
                            output logic [7:0] model, output logic [7:0] miso_seen,
                            output logic unstable);
        logic b;
        logic m0, m1;
        pull_msg_val  = pull_b[7];
        pull_msg_spc  = pull_b[6];
        pull_msg_data = pull_b[5:0];
        model     = pull_b;
        miso_seen = '0;
        unstable  = 1'b0;
        cs_n = 1'b0;
        tick(8);
        for (int i = 0; i < nbit; i++) begin
            if (i == abort_at) begin
                reset_n = 1'b0;
                tick(2);
                return;
            end
            b = (i < 8) ? mosi_b[7-i] : 1'b0;
            mosi = b;
            tick(4);
            m0 = miso;
            sclk = 1'b1;
            tick(1);
            m1 = miso;
            if (i < 8) miso_seen[7-i] = m0;
            if (m0 !== m1) unstable = 1'b1;
            model = {model[6:0], b};
            tick(3);
            sclk = 1'b0;
        end
        tick(4);
        cs_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        pull_msg_val = 1'b0; pull_msg_spc = 1'b0; pull_msg_data = '0;
        tick(3);
        n_cmp++;
        if ({miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data, frame_err} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 000",
                     {miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data, frame_err});
        end
        reset_n = 1'b1;
        tick(6);
        n_cmp++;
        if ({n_pull, n_push, n_err} !== {32'd0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL idle_after_reset: pull=%0d push=%0d err=%0d want 0/0/0", n_pull, n_push, n_err);
        end
    endtask

    task automatic test_full_frame;
        logic [7:0] model, mseen;
        logic unst;
        int p0, q0, e0;
        p0 = n_pull; q0 = n_push; e0 = n_err;
        do_frame(8, 8'b10_101101, {1'b1, 1'b1, 6'h15}, -1, model, mseen, unst);
        exp_q.push_back(8'hAD);
        tick(6);
        n_cmp++;
        if (n_pull - p0 != 1 || n_push - q0 != 1 || n_err != e0) begin
            n_bad++;
            $display("FAIL full_pulses: pull=%0d push=%0d err=%0d want 1/1/0", n_pull - p0, n_push - q0, n_err - e0);
        end
        n_cmp++;
        if ({push_msg_val_wrt, push_msg_val_rd, push_msg_data} !== {1'b1, 1'b0, 6'h2D}) begin
            n_bad++;
            $display("FAIL full_fields: got wrt=%b rd=%b data=%h want 1 0 2d",
                     push_msg_val_wrt, push_msg_val_rd, push_msg_data);
        end
        n_cmp++;
        if (mseen !== 8'b1101_0101) begin
            n_bad++;
            $display("FAIL miso_bits: got %b want 11010101", mseen);
        end
        n_cmp++;
        if (unst !== 1'b0) begin
            n_bad++;
            $display("FAIL miso_stable: got unstable=%b want 0", unst);
        end
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL full_scoreboard: got no push want %h", exp_q.pop_front());
            end else if (obs_q[0] !== exp_q[0]) begin
                n_bad++;
                $display("FAIL full_scoreboard: got %h want %h", obs_q.pop_front(), exp_q.pop_front());
            end else begin
                void'(obs_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_short_frame;
        logic [7:0] model, mseen;
        logic unst;
        int q0, e0;
        q0 = n_push; e0 = n_err;
        do_frame(5, 8'b10110011, 8'h3C, -1, model, mseen, unst);
        tick(6);
        n_cmp++;
        if (n_err - e0 != 1 || n_push != q0) begin
            n_bad++;
            $display("FAIL short_pulses: err=%0d push=%0d want 1/0", n_err - e0, n_push - q0);
        end
        n_cmp++;
        if ({push_msg_val_wrt, push_msg_val_rd, push_msg_data} !== model) begin
            n_bad++;
            $display("FAIL short_partial: got %h want %h",
                     {push_msg_val_wrt, push_msg_val_rd, push_msg_data}, model);
        end
        q0 = n_push; e0 = n_err;
        do_frame(8, 8'h5A, 8'h81, -1, model, mseen, unst);
        exp_q.push_back(model);
        tick(6);
        n_cmp++;
        if (n_push - q0 != 1 || n_err != e0) begin
            n_bad++;
            $display("FAIL short_recover: push=%0d err=%0d want 1/0", n_push - q0, n_err - e0);
        end
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
                n_bad++;
                $display("FAIL short_scoreboard: got %h want %h",
                         (obs_q.size() > 0) ? obs_q[0] : 8'hxx, exp_q[0]);
            end
            if (obs_q.size() > 0) void'(obs_q.pop_front());
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_long_frame;
        logic [7:0] model, mseen;
        logic unst;
        int q0, e0;
        q0 = n_push; e0 = n_err;
        do_frame(9, 8'hF0, 8'h42, -1, model, mseen, unst);
        tick(6);
        n_cmp++;
        if (n_err - e0 != 1 || n_push != q0) begin
            n_bad++;
            $display("FAIL long_pulses: err=%0d push=%0d want 1/0", n_err - e0, n_push - q0);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] model, mseen;
        logic unst;
        int p0, q0, e0;
        q0 = n_push; e0 = n_err;
        do_frame(8, 8'hC3, 8'hFF, 4, model, mseen, unst);
        n_cmp++;
        if ({miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data, frame_err} !== 12'h000) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h want 000",
                     {miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data, frame_err});
        end
        // Release with cs_n still low: must not start a frame.
        p0 = n_pull;
        reset_n = 1'b1;
        tick(10);
        n_cmp++;
        if (n_pull != p0 || n_push != q0 || n_err != e0) begin
            n_bad++;
            $display("FAIL midreset_quiet: pull=%0d push=%0d err=%0d want 0/0/0", n_pull - p0, n_push - q0, n_err - e0);
        end
        cs_n = 1'b1;
        tick(4);
        do_frame(8, 8'b01_110010, 8'h00, -1, model, mseen, unst);
        exp_q.push_back(8'b01_110010);
        tick(6);
        n_cmp++;
        if (n_push - q0 != 1 || n_err != e0) begin
            n_bad++;
            $display("FAIL midreset_recover: push=%0d err=%0d want 1/0", n_push - q0, n_err - e0);
        end
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
                n_bad++;
                $display("FAIL midreset_scoreboard: got %h want %h",
                         (obs_q.size() > 0) ? obs_q[0] : 8'hxx, exp_q[0]);
            end
            if (obs_q.size() > 0) void'(obs_q.pop_front());
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] model, mseen;
        logic [7:0] held;
        logic held_miso;
        logic unst;
        int p0, q0, e0;
        p0 = n_pull; q0 = n_push; e0 = n_err;
        held = {push_msg_val_wrt, push_msg_val_rd, push_msg_data};
        held_miso = miso;
        for (int i = 0; i < 6; i++) begin
            mosi = i[0];
            sclk = ~sclk;
            tick(2);
        end
        sclk = 1'b0;
        tick(4);
        n_cmp++;
        if (n_pull != p0 || n_push != q0 || n_err != e0) begin
            n_bad++;
            $display("FAIL idle_sclk_events: pull=%0d push=%0d err=%0d want 0/0/0", n_pull - p0, n_push - q0, n_err - e0);
        end
        n_cmp++;
        if ({push_msg_val_wrt, push_msg_val_rd, push_msg_data, miso} !== {held, held_miso}) begin
            n_bad++;
            $display("FAIL idle_sclk_hold: got %h want %h",
                     {push_msg_val_wrt, push_msg_val_rd, push_msg_data, miso}, {held, held_miso});
        end
        do_frame(8, 8'hA7, 8'h55, -1, model, mseen, unst);
        exp_q.push_back(8'hA7);
        do_frame(8, 8'h1E, 8'hAA, -1, model, mseen, unst);
        exp_q.push_back(8'h1E);
        tick(6);
        n_cmp++;
        if (n_pull - p0 != 2 || n_push - q0 != 2 || n_err != e0) begin
            n_bad++;
            $display("FAIL b2b_pulses: pull=%0d push=%0d err=%0d want 2/2/0", n_pull - p0, n_push - q0, n_err - e0);
        end
        n_cmp++;
        if (mseen !== 8'hAA) begin
            n_bad++;
            $display("FAIL b2b_miso: got %h want aa", mseen);
        end
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
                n_bad++;
                $display("FAIL b2b_scoreboard: got %h want %h",
                         (obs_q.size() > 0) ? obs_q[0] : 8'hxx, exp_q[0]);
            end
            if (obs_q.size() > 0) void'(obs_q.pop_front());
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL extra_pushes: got %0d leftover want 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_long_frame();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
